// File: rtl/fetch_redirect_scheduler_pkg.sv
// Shared types and defaults for the fetch redirect scheduler and its halt FSM.
package fetch_redirect_scheduler_pkg;

   localparam int unsigned DefPcWidth       = 32;
   localparam int unsigned DefBrWidth       = 2;
   localparam int unsigned DefWaitDelay     = 2;
   localparam int unsigned DefMaxHalt       = 63;
   localparam bit          DefStopOnMispred = 1'b1;

   typedef enum logic [1:0] {
      SrcNone = 2'd0,
      SrcRw   = 2'd1,
      SrcRn   = 2'd2,
      SrcInt  = 2'd3
   } redirect_src_e;

   typedef enum logic [1:0] {
      PhFetch = 2'd0,
      PhDelay = 2'd1,
      PhHalt  = 2'd2
   } halt_phase_e;

   // An incoming flush may replace a held one when its priority is higher or equal.
   // Only rw and rename are ever held, and rw outranks rename.
   function automatic logic src_may_replace(redirect_src_e incoming, redirect_src_e held);
      return (incoming == SrcRw) || (held != SrcRw);
   endfunction

endpackage

// File: rtl/redirect_halt_fsm.sv
// Stop-fetch-on-mispredict FSM: delays, then bubbles the front end until recovery or timeout.
module redirect_halt_fsm
   import fetch_redirect_scheduler_pkg::*;
#(
   parameter int unsigned BR_WIDTH        = DefBrWidth,
   parameter int unsigned WAIT_DELAY      = DefWaitDelay,
   parameter int unsigned MAX_HALT        = DefMaxHalt,
   parameter bit          STOP_ON_MISPRED = DefStopOnMispred
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [BR_WIDTH-1:0] br_mispred,
   input  logic                rw_flush,
   input  logic                commit_phase,
   output halt_phase_e         state,
   output logic                fetch_bubble,
   output logic [15:0]         mispred_cnt
);

   localparam int unsigned DlyW  = (WAIT_DELAY > 1) ? $clog2(WAIT_DELAY) : 1;
   localparam int unsigned HaltW = (MAX_HALT > 0) ? $clog2(MAX_HALT + 1) : 1;
   localparam logic [DlyW-1:0]  DlyLoad  = DlyW'(WAIT_DELAY - 1);
   localparam logic [HaltW-1:0] HaltLast = HaltW'(MAX_HALT);

   halt_phase_e      state_q, state_d;
   logic [DlyW-1:0]  dly_cnt_q, dly_cnt_d;
   logic [HaltW-1:0] halt_cnt_q, halt_cnt_d;
   logic [15:0]      mispred_cnt_q, mispred_cnt_d;

   // State and counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= PhFetch;
         dly_cnt_q     <= '0;
         halt_cnt_q    <= '0;
         mispred_cnt_q <= '0;
      end else begin
         state_q       <= state_d;
         dly_cnt_q     <= dly_cnt_d;
         halt_cnt_q    <= halt_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   // Next-state and counter update; mispredicts outside FETCH are ignored
   always_comb begin
      state_d       = state_q;
      dly_cnt_d     = dly_cnt_q;
      halt_cnt_d    = halt_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
      unique case (state_q)
         PhFetch: begin
            if (STOP_ON_MISPRED && (|br_mispred) && !rw_flush) begin
               state_d   = PhDelay;
               dly_cnt_d = DlyLoad;
            end
         end
         PhDelay: begin
            if (rw_flush || commit_phase) begin
               state_d = PhFetch;
            end else if (dly_cnt_q == '0) begin
               state_d    = PhHalt;
               halt_cnt_d = '0;
               if (mispred_cnt_q != 16'hFFFF) begin
                  mispred_cnt_d = mispred_cnt_q + 16'd1;
               end
            end else begin
               dly_cnt_d = dly_cnt_q - DlyW'(1);
            end
         end
         PhHalt: begin
            if (rw_flush || commit_phase) begin
               state_d = PhFetch;
            end else if (halt_cnt_q == HaltLast) begin
               state_d = PhFetch;
            end else begin
               halt_cnt_d = halt_cnt_q + HaltW'(1);
            end
         end
         default: state_d = PhFetch;
      endcase
   end

   // Outputs; the recovery cycle itself is never bubbled
   always_comb begin
      state        = state_q;
      mispred_cnt  = mispred_cnt_q;
      fetch_bubble = STOP_ON_MISPRED && (state_q == PhHalt) && !rw_flush;
   end

endmodule

// File: rtl/fetch_redirect_scheduler.sv
// Arbitrates rw / rename / interrupt redirects into the next-PC stage, holding them across stalls.
module fetch_redirect_scheduler
   import fetch_redirect_scheduler_pkg::*;
#(
   parameter int unsigned PC_WIDTH        = DefPcWidth,
   parameter int unsigned BR_WIDTH        = DefBrWidth,
   parameter int unsigned WAIT_DELAY      = DefWaitDelay,
   parameter int unsigned MAX_HALT        = DefMaxHalt,
   parameter bit          STOP_ON_MISPRED = DefStopOnMispred
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall,
   input  logic                rw_flush,
   input  logic [PC_WIDTH-1:0] rw_pc,
   input  logic                rn_flush,
   input  logic [PC_WIDTH-1:0] rn_pc,
   input  logic                commit_phase,
   input  logic [BR_WIDTH-1:0] br_mispred,
   input  logic                int_req,
   input  logic [PC_WIDTH-1:0] int_addr,
   output logic                int_ack,
   output logic                redirect_valid,
   output logic [PC_WIDTH-1:0] redirect_pc,
   output logic [1:0]          redirect_src,
   output logic                fetch_bubble,
   output logic [1:0]          halt_state,
   output logic [15:0]         mispred_cnt
);

   halt_phase_e         phase;
   logic                pend_valid_q, pend_valid_d;
   logic [PC_WIDTH-1:0] pend_pc_q, pend_pc_d;
   redirect_src_e       pend_src_q, pend_src_d;
   redirect_src_e       in_src, win_src;
   logic [PC_WIDTH-1:0] in_pc;

   redirect_halt_fsm #(
      .BR_WIDTH        (BR_WIDTH),
      .WAIT_DELAY      (WAIT_DELAY),
      .MAX_HALT        (MAX_HALT),
      .STOP_ON_MISPRED (STOP_ON_MISPRED)
   ) u_halt_fsm (
      .clk          (clk),
      .rst          (rst),
      .br_mispred   (br_mispred),
      .rw_flush     (rw_flush),
      .commit_phase (commit_phase),
      .state        (phase),
      .fetch_bubble (fetch_bubble),
      .mispred_cnt  (mispred_cnt)
   );

   assign halt_state   = phase;
   assign redirect_src = win_src;

   // Pending redirect register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_valid_q <= 1'b0;
         pend_pc_q    <= '0;
         pend_src_q   <= SrcNone;
      end else begin
         pend_valid_q <= pend_valid_d;
         pend_pc_q    <= pend_pc_d;
         pend_src_q   <= pend_src_d;
      end
   end

   // Hold flushes during stall; otherwise pick rw > pending > rename > interrupt
   always_comb begin
      pend_valid_d   = pend_valid_q;
      pend_pc_d      = pend_pc_q;
      pend_src_d     = pend_src_q;
      in_src         = rw_flush ? SrcRw : SrcRn;
      in_pc          = rw_flush ? rw_pc : rn_pc;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      win_src        = SrcNone;
      int_ack        = 1'b0;
      if (stall) begin
         if ((rw_flush || rn_flush) &&
             (!pend_valid_q || src_may_replace(in_src, pend_src_q))) begin
            pend_valid_d = 1'b1;
            pend_pc_d    = in_pc;
            pend_src_d   = in_src;
         end
      end else begin
         // Pending is consumed, or squashed by a live rw flush
         pend_valid_d = 1'b0;
         if (rw_flush) begin
            redirect_valid = 1'b1;
            redirect_pc    = rw_pc;
            win_src        = SrcRw;
         end else if (pend_valid_q) begin
            redirect_valid = 1'b1;
            redirect_pc    = pend_pc_q;
            win_src        = pend_src_q;
         end else if (rn_flush) begin
            redirect_valid = 1'b1;
            redirect_pc    = rn_pc;
            win_src        = SrcRn;
         end else if (int_req && (phase == PhFetch)) begin
            redirect_valid = 1'b1;
            redirect_pc    = int_addr;
            win_src        = SrcInt;
            int_ack        = 1'b1;
         end
      end
      // Reset silences the combinational outputs immediately
      if (!rst) begin
         redirect_valid = 1'b0;
         redirect_pc    = '0;
         win_src        = SrcNone;
         int_ack        = 1'b0;
      end
   end

endmodule
